pwm_multi: RTL

Multi-channel PWM generator that succeeds the single-channel pwm block. It provides NUM_CH independent channels driven from one shared, runtime-programmable prescaler tick. Per-channel configuration passes through a write port into shadow registers, which are applied glitch-free at period boundaries. Each channel has its own phase offset, enable and period-end strobe, and all channels can be re-aligned together by a global sync.

---
 rtl/pwm_multi.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH independent PWM channels sharing one programmable
// prescaler tick. Each channel has a shadow config (written through the
// cfg_* port) that is copied to the active config only at safe points:
// a period wrap, while disabled, on an enable rising edge, or on sync_start.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   prescale          tick every prescale+1 clocks
//   sync_start        restart every enabled channel at its phase
//   cfg_*             shadow-config write port (cfg_ch >= NUM_CH ignored)
//   enable            per-channel run enable
//   rd_ch / rd_*      combinational readback of the active config of rd_ch
//   pwm_out           registered PWM outputs
//   period_end        one-clock strobe when a channel's counter wraps
module pwm_multi #(
  parameter int NUM_CH         = 4,
  parameter int CH_WIDTH       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int WAVE_LEN_WIDTH = 11,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      sync_start,
  input  logic                      cfg_we,
  input  logic [CH_WIDTH-1:0]       cfg_ch,
  input  logic [WAVE_LEN_WIDTH-1:0] cfg_wave_length,
  input  logic [WAVE_LEN_WIDTH-1:0] cfg_pulse_width,
  input  logic [WAVE_LEN_WIDTH-1:0] cfg_phase,
  input  logic                      cfg_active_high,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [CH_WIDTH-1:0]       rd_ch,
  output logic [WAVE_LEN_WIDTH-1:0] rd_wave_length,
  output logic [WAVE_LEN_WIDTH-1:0] rd_pulse_width,
  output logic [WAVE_LEN_WIDTH-1:0] rd_phase,
  output logic                      rd_active_high,
  output logic                      rd_pending,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic [NUM_CH-1:0]         period_end
);
  localparam int W = WAVE_LEN_WIDTH;

  // Shared prescaler. Using >= (not ==) means lowering prescale below the
  // current count ticks on the very next clock instead of wrapping around.
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                      tick;

  always_comb begin
    tick = (pcnt_q >= prescale) && !sync_start;
    if (sync_start || (pcnt_q >= prescale)) pcnt_d = '0;
    else                                    pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

  logic [NUM_CH-1:0][W-1:0] act_wl, act_pw, act_ph;
  logic [NUM_CH-1:0]        act_ah, act_pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [W-1:0] wl_q, pw_q, ph_q, swl_q, spw_q, sph_q, cnt_q;
    logic         ah_q, sah_q, pend_q, en_d_q, pwm_q, pe_q;
    logic         wr, rise, restart, wrap, apply;
    logic [W-1:0] wl_n, pw_n, ph_n;
    logic         ah_n;

    always_comb begin
      // Out-of-range cfg_ch never matches any channel index.
      wr      = cfg_we && (cfg_ch == CH_WIDTH'(i));
      rise    = enable[i] && !en_d_q;
      restart = enable[i] && (sync_start || rise);
      wrap    = enable[i] && tick && (wl_q != '0) && (cnt_q >= wl_q - W'(1));
      apply   = pend_q && (wrap || !enable[i] || restart);
      // Config in force after this edge; the tick path below still uses the
      // pre-apply values so the final period is finished with the old shape.
      wl_n    = apply ? swl_q : wl_q;
      pw_n    = apply ? spw_q : pw_q;
      ph_n    = apply ? sph_q : ph_q;
      ah_n    = apply ? sah_q : ah_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wl_q <= '0; pw_q <= '0; ph_q <= '0; ah_q <= 1'b1;
        swl_q <= '0; spw_q <= '0; sph_q <= '0; sah_q <= 1'b1;
        pend_q <= 1'b0; en_d_q <= 1'b0; cnt_q <= '0;
        pwm_q <= 1'b0; pe_q <= 1'b0;
      end else begin
        en_d_q <= enable[i];
        wl_q <= wl_n; pw_q <= pw_n; ph_q <= ph_n; ah_q <= ah_n;
        // A write landing on an apply edge wins pending: the apply took the
        // older shadow, the new one waits for the next opportunity.
        if (wr) begin
          swl_q <= cfg_wave_length; spw_q <= cfg_pulse_width;
          sph_q <= cfg_phase;       sah_q <= cfg_active_high;
          pend_q <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
        pe_q <= 1'b0;
        if (!enable[i]) begin
          cnt_q <= '0;
          pwm_q <= ~ah_n;
        end else if (restart) begin
          cnt_q <= (ph_n >= wl_n) ? '0 : ph_n;
        end else if (tick) begin
          if (wl_q == '0) begin
            cnt_q <= '0;
            pwm_q <= ~ah_q;
          end else begin
            pwm_q <= (cnt_q < pw_q) ? ah_q : ~ah_q;
            if (wrap) begin
              cnt_q <= '0;
              pe_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + W'(1);
            end
          end
        end
      end
    end

    assign pwm_out[i]    = pwm_q;
    assign period_end[i] = pe_q;
    assign act_wl[i]     = wl_q;
    assign act_pw[i]     = pw_q;
    assign act_ph[i]     = ph_q;
    assign act_ah[i]     = ah_q;
    assign act_pend[i]   = pend_q;
  end

  // Readback mux; an out-of-range rd_ch reads all zeros.
  always_comb begin
    rd_wave_length = '0;
    rd_pulse_width = '0;
    rd_phase       = '0;
    rd_active_high = 1'b0;
    rd_pending     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == CH_WIDTH'(k)) begin
        rd_wave_length = act_wl[k];
        rd_pulse_width = act_pw[k];
        rd_phase       = act_ph[k];
        rd_active_high = act_ah[k];
        rd_pending     = act_pend[k];
      end
    end
  end
endmodule
